inst_fetch_buf: RTL and testbench
=================================

INST_FETCH_BUF -- requirements
Module: inst_fetch_buf

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h8000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of instruction buffer entries; legal values are 2 and 4.
REQ-003 Port clk SHALL be an input of width 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be an input of width 1: the reset, asynchronous and active-low.
REQ-005 Port redirect_valid SHALL be an input of width 1: flush the buffer and restart fetch at redirect_pc.
REQ-006 Port redirect_pc SHALL be an input of width 32: the new fetch address.
REQ-007 Port mem_req SHALL be an output of width 1: instruction memory request valid.
REQ-008 Port mem_addr SHALL be an output of width 32: the request address, word aligned.
REQ-009 Port mem_gnt SHALL be an input of width 1: the request is accepted in a cycle where mem_req and mem_gnt are both high.
REQ-010 Port mem_rvalid SHALL be an input of width 1: response data valid.
REQ-011 Port mem_rdata SHALL be an input of width 32: response instruction word.
REQ-012 Port out_valid SHALL be an output of width 1: an instruction is presented to the decoder.
REQ-013 Port out_inst SHALL be an output of width 32: the presented instruction.
REQ-014 Port out_pc SHALL be an output of width 32: the PC of the presented instruction.
REQ-015 Port out_ready SHALL be an input of width 1: the decoder accepts the instruction in a cycle where out_valid and out_ready are both high.

Function
REQ-016 The FSM SHALL have states IDLE (no request), REQ (mem_req high, waiting for gnt) and WAIT (granted, waiting for rvalid); at most one request is outstanding.
REQ-017 Transition IDLE->REQ SHALL occur when buffer occupancy is below DEPTH.
REQ-018 Transition REQ->WAIT SHALL occur on gnt.
REQ-019 Transition WAIT->REQ SHALL occur on rvalid when space remains after the write; otherwise WAIT->IDLE on rvalid.
REQ-020 mem_req and mem_addr SHALL stay stable while in REQ until gnt.
REQ-021 fetch_pc SHALL advance by 4, wrapping modulo 2^32, on each gnt.
REQ-022 On rvalid with no kill pending, {mem_rdata, PC of the request} SHALL be written to the buffer tail.
REQ-023 The buffer SHALL be FIFO ordered, with out_inst and out_pc taken from the head.
REQ-024 out_valid SHALL be high exactly when the buffer is not empty.
REQ-025 The minimum latency from gnt to out_valid SHALL be 1 cycle after rvalid, which is registered.
REQ-026 On a cycle with simultaneous push and pop, occupancy SHALL be unchanged and both operations take effect.
REQ-027 Space accounting SHALL ensure that occupancy plus outstanding requests never exceeds DEPTH, so a push never occurs while full.
REQ-028 On redirect_valid, the buffer SHALL be emptied, fetch_pc set to redirect_pc with bits [1:0] cleared, and a pop in the same cycle ignored.
REQ-029 If redirect_valid occurs in WAIT, a kill flag SHALL be set and the next rvalid discarded, after which the FSM goes to REQ at the new PC.
REQ-030 If redirect_valid occurs in REQ without gnt, mem_addr SHALL switch to the new PC on the following cycle.
REQ-031 If redirect_valid occurs in REQ with gnt, the block SHALL go to WAIT with kill set.
REQ-032 If redirect_valid and rvalid coincide, the response SHALL be discarded and kill cleared.

Reset
REQ-033 While rst is low, the FSM SHALL be in IDLE, fetch_pc = RESET_PC, buffer empty, kill = 0, mem_req = 0, out_valid = 0, and out_inst/out_pc = 0.
REQ-034 Reset SHALL act asynchronously; assertion mid-transaction SHALL abandon the outstanding request, and any later rvalid before a new gnt SHALL be ignored.
REQ-035 The first mem_req SHALL assert in the first cycle after rst deasserts.

Configuration
REQ-036 With macro IFB_PERF_CNT_EN defined, the block SHALL add output perf_stall_cnt (32 bits, reset 0), which increments, saturating, in every cycle with out_ready high and out_valid low.
REQ-037 Without IFB_PERF_CNT_EN, the port and the counter SHALL be absent.

Structure
REQ-038 The FSM state enum, RESET_PC default and instruction width constant SHALL reside in a shared package npc_pkg.
REQ-039 The buffer SHALL be a sub-module ifb_fifo (parameter DEPTH, push/pop/flush, full/empty, count).

Verification
REQ-040 Reset, memory always grants, rvalid 1 cycle after gnt, out_ready = 1: mem_addr SHALL be 8000_0000, 8000_0004, ...; out_pc SHALL match in order; out_inst SHALL equal mem_rdata.
REQ-041 out_ready = 0 for 10 cycles: exactly DEPTH instructions SHALL be buffered, mem_req SHALL stay low, and no data SHALL be lost when out_ready returns to 1.
REQ-042 redirect_valid to 8000_0102 while in WAIT: the stale rvalid SHALL be dropped, the next mem_addr SHALL be 8000_0100, and the first out_pc after the redirect SHALL be 8000_0100.
REQ-043 Simultaneous push and pop at occupancy 1 for 20 cycles: occupancy SHALL stay 1 and ordering SHALL be preserved.
REQ-044 fetch_pc = FFFF_FFFC: the next mem_addr SHALL be 0000_0000.
REQ-045 rst asserted in WAIT, then rvalid pulsed: out_valid SHALL stay 0; with IFB_PERF_CNT_EN defined, perf_stall_cnt SHALL read 0 after reset and SHALL count stall cycles.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared constants and types for the next-PC / instruction fetch slice.
package npc_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } ifb_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/ifb_fifo.sv
// Small FIFO holding {instruction, pc} entries for the fetch buffer.
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
module ifb_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [DATA_W-1:0]            head_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~flush & ~empty;
  // A write into a full FIFO is allowed only when the head leaves in the same cycle.
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: one outstanding memory request feeding a small FIFO.
// Optional macro IFB_PERF_CNT_EN adds the perf_stall_cnt output.
module inst_fetch_buf
  import npc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic [XLEN-1:0]   out_pc,
  input  logic              out_ready
`ifdef IFB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH+1);

  ifb_state_e              state;
  ifb_state_e              state_nxt;
  logic                    kill;
  logic                    kill_nxt;
  logic [XLEN-1:0]         fetch_pc;
  logic [XLEN-1:0]         req_pc;
  logic                    flush;
  logic                    gnt;
  logic                    rsp;
  logic                    push;
  logic                    pop;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_nxt;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [INST_W+XLEN-1:0]  head;

  assign flush = redirect_valid;
  assign gnt   = mem_req & mem_gnt;
  assign rsp   = (state == WAIT) & mem_rvalid;
  assign push  = rsp & ~kill & ~flush;
  assign pop   = out_valid & out_ready & ~flush;

  always_comb begin
    count_nxt = count;
    if (flush) count_nxt = '0;
    else       count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  // The in-flight request always owns a slot, so a response can never find the FIFO full.
  always_comb begin
    state_nxt = state;
    kill_nxt  = kill;
    unique case (state)
      IDLE: begin
        if (!fifo_full || pop || flush) state_nxt = REQ;
      end
      REQ: begin
        if (gnt) begin
          state_nxt = WAIT;
          kill_nxt  = flush;
        end
      end
      WAIT: begin
        if (rsp) begin
          kill_nxt  = 1'b0;
          state_nxt = (count_nxt < CNT_W'(DEPTH)) ? REQ : IDLE;
        end else if (flush) begin
          kill_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        kill_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      kill     <= 1'b0;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
      if (flush)    fetch_pc <= word_align(redirect_pc);
      else if (gnt) fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (gnt) req_pc <= fetch_pc;
  end

  assign mem_req  = (state == REQ);
  assign mem_addr = word_align(fetch_pc);

  ifb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (INST_W + XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({mem_rdata, req_pc}),
    .pop       (pop),
    .flush     (flush),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign out_valid = ~fifo_empty;
  assign out_inst  = fifo_empty ? '0 : head[INST_W+XLEN-1:XLEN];
  assign out_pc    = fifo_empty ? '0 : head[XLEN-1:0];

`ifdef IFB_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        perf_stall_cnt <= '0;
    else if (out_ready && !out_valid) perf_stall_cnt <= sat_inc(perf_stall_cnt);
  end
`endif

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Randomized bench for inst_fetch_buf: a memory responder plus a queue-based
// model of the fetched instruction stream (grant addresses, buffered entries).
module tb_inst_fetch_buf;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;
`ifdef IFB_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
`endif

  inst_fetch_buf #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
`ifdef IFB_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] gnt_log[$];
  logic [31:0] acc_log[$];
  int          errors = 0;
  int          checks = 0;

  int          gnt_pct = 100, rsp_dly_max = 0, rdy_pct = 100, redir_pct = 0;
  bit          ready_follows_rvalid = 0;
  bit          drive_redirect = 0;
  logic [31:0] drive_redirect_pc = '0;

  bit          infl_vld, infl_stale;
  logic [31:0] infl_pc, infl_inst;
  int          infl_dly;
  logic [31:0] model_pc;
  bit          prev_req_pending;
  logic [31:0] prev_addr;
  logic [31:0] exp_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    infl_vld         = 0;
    infl_stale       = 0;
    infl_dly         = 0;
    model_pc         = RST_PC;
    prev_req_pending = 0;
    exp_stall        = '0;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step();
    logic        gnt_ev, rsp_ev, acc_ev, redir, rsp_stale;
    logic [31:0] rsp_pc, rsp_inst;
    ent_t        e;
    mem_gnt        = ($urandom_range(99) < gnt_pct);
    rsp_ev         = infl_vld && (infl_dly == 0);
    rsp_pc         = infl_pc;
    rsp_inst       = infl_inst;
    rsp_stale      = infl_stale;
    mem_rvalid     = rsp_ev;
    mem_rdata      = rsp_ev ? infl_inst : $urandom;
    redir          = drive_redirect || ($urandom_range(99) < redir_pct);
    redirect_valid = redir;
    redirect_pc    = drive_redirect ? drive_redirect_pc : 32'h8000_0000 + 32'($urandom_range(1023));
    out_ready      = ready_follows_rvalid ? rsp_ev : ($urandom_range(99) < rdy_pct);
    #1;
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("out_pc", out_pc, exp_q[0].pc);
      chk("out_inst", out_inst, exp_q[0].inst);
    end
    if (prev_req_pending) begin
      chk("req_hold", 32'(mem_req), 32'd1);
      chk("addr_hold", mem_addr, prev_addr);
    end
`ifdef IFB_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt, exp_stall);
    if (out_ready && !out_valid && exp_stall != '1) exp_stall = exp_stall + 32'd1;
`endif
    gnt_ev = mem_req && mem_gnt;
    acc_ev = out_valid && out_ready && !redir;
    if (rsp_ev) infl_vld = 0;
    if (gnt_ev) begin
      chk("gnt_addr", mem_addr, model_pc);
      chk("one_outstanding", 32'(infl_vld), 32'd0);
      gnt_log.push_back(mem_addr);
      infl_vld   = 1;
      infl_stale = 0;
      infl_pc    = model_pc;
      infl_inst  = $urandom;
      infl_dly   = $urandom_range(rsp_dly_max);
      model_pc   = model_pc + 32'd4;
    end else if (infl_vld && infl_dly > 0) begin
      infl_dly--;
    end
    if (acc_ev && exp_q.size() != 0) begin
      acc_log.push_back(exp_q[0].pc);
      e = exp_q.pop_front();
    end
    if (redir) begin
      exp_q.delete();
      if (infl_vld) infl_stale = 1;
      model_pc = redirect_pc & ~32'd3;
    end else if (rsp_ev && !rsp_stale) begin
      e.pc   = rsp_pc;
      e.inst = rsp_inst;
      exp_q.push_back(e);
    end
    prev_req_pending = mem_req && !mem_gnt && !redir;
    prev_addr        = mem_addr;
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 0;
  endtask

  task automatic release_reset(input string tag);
    rst        = 1;
    mem_gnt    = 0;
    out_ready  = 0;
    @(posedge clk);
    #1;
    chk({tag, "_first_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_first_addr"}, mem_addr, RST_PC);
    @(negedge clk);
    mem_rvalid = 0;
  endtask

  initial begin
    int n0;
    bit ok;
    rst = 0; redirect_valid = 0; redirect_pc = '0; mem_gnt = 0;
    mem_rvalid = 0; mem_rdata = '0; out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    @(negedge clk);
    release_reset("init");

    // Streaming: always grant, one-cycle response, decoder always ready.
    gnt_log.delete(); acc_log.delete();
    repeat (30) step();
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", (i < gnt_log.size()) ? gnt_log[i] : 32'hDEAD_BEEF, RST_PC + 32'(4 * i));
      chk("seq_pc", (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_BEEF, RST_PC + 32'(4 * i));
    end

    // Decoder stalls: buffer fills to DEPTH and fetching stops.
    rdy_pct = 0;
    repeat (10) step();
    chk("full_occ", 32'(exp_q.size()), 32'(DEPTH));
    chk("full_req", 32'(mem_req), 32'd0);
    chk("full_valid", 32'(out_valid), 32'd1);
    rdy_pct = 100;
    repeat (20) step();

    // Occupancy held at 1 by popping exactly when a response is written.
    rdy_pct = 0;
    for (int i = 0; i < 20 && exp_q.size() != 1; i++) step();
    chk("pp_reach", 32'(exp_q.size()), 32'd1);
    ready_follows_rvalid = 1;
    n0 = acc_log.size();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("pp_occ", 32'(exp_q.size()), 32'd1);
    end
    chk("pp_pairs", 32'(acc_log.size() - n0 >= 8), 32'd1);
    ready_follows_rvalid = 0;
    rdy_pct = 100;

    // Redirect while waiting for a response.
    rsp_dly_max = 3;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (infl_vld && !infl_stale && infl_dly > 0) begin ok = 1; break; end
      step();
    end
    chk("redir_reach_wait", 32'(ok), 32'd1);
    drive_redirect = 1; drive_redirect_pc = 32'h8000_0102;
    step();
    drive_redirect = 0; rsp_dly_max = 0;
    gnt_log.delete(); acc_log.delete();
    repeat (20) step();
    chk("redir_addr", (gnt_log.size() > 0) ? gnt_log[0] : 32'hDEAD_BEEF, 32'h8000_0100);
    chk("redir_out_pc", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, 32'h8000_0100);

    // Fetch address wraps at the top of the address space.
    drive_redirect = 1; drive_redirect_pc = 32'hFFFF_FFFC;
    step();
    drive_redirect = 0;
    gnt_log.delete();
    for (int i = 0; i < 40 && gnt_log.size() < 2; i++) step();
    chk("wrap_addr0", (gnt_log.size() > 0) ? gnt_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wrap_addr1", (gnt_log.size() > 1) ? gnt_log[1] : 32'hDEAD_BEEF, 32'h0000_0000);

    // Mixed random traffic with redirects.
    gnt_pct = 60; rsp_dly_max = 3; rdy_pct = 70; redir_pct = 5;
    repeat (400) step();

    // Asynchronous reset while a response is outstanding.
    gnt_pct = 100; rsp_dly_max = 4; rdy_pct = 100; redir_pct = 0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (infl_vld && !infl_stale && infl_dly >= 2) begin ok = 1; break; end
      step();
    end
    chk("rst_reach_wait", 32'(ok), 32'd1);
    #2 rst = 0;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_pc", out_pc, 32'd0);
    chk("arst_inst", out_inst, 32'd0);
    mem_gnt = 0; out_ready = 0; mem_rvalid = 1; mem_rdata = $urandom;
    @(negedge clk);
    model_reset();
    release_reset("post");
    chk("stale_drop1", 32'(out_valid), 32'd0);
    mem_rvalid = 1; mem_rdata = $urandom;
    @(posedge clk);
    #1;
    chk("stale_drop2", 32'(out_valid), 32'd0);
`ifdef IFB_PERF_CNT_EN
    chk("perf_after_rst", perf_stall_cnt, 32'd0);
`endif
    @(negedge clk);
    mem_rvalid = 0;
    gnt_log.delete();
    rdy_pct = 80;
    repeat (40) step();
    chk("post_rst_addr", (gnt_log.size() > 0) ? gnt_log[0] : 32'hDEAD_BEEF, RST_PC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
